// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and reset vector.
// S_HALT exists only when IFETCH_MISALIGN_TRAP_EN is defined.
package ifetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
`ifdef IFETCH_MISALIGN_TRAP_EN
      S_VALID = 2'd2,
      S_HALT  = 2'd3
`else
      S_VALID = 2'd2
`endif
   } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the valid/ready channel to decode.
// The master modport is the fetch unit, the slave modport is memory plus decode.
interface ifetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output instr,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  instr,
      input  instr_valid,
      output instr_ready
   );

endinterface

// File: rtl/ifetch_unit_pc_reg.sv
// Architectural PC register with async reset and load enable.
// Without IFETCH_MISALIGN_TRAP_EN the loaded value is forced word-aligned.
module pc_reg
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [31:0] npc_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

`ifdef IFETCH_MISALIGN_TRAP_EN
   // The trap logic wants to see the offending address, so keep it unmodified.
   assign pc_d = npc_i;
`else
   assign pc_d = npc_i & 32'hFFFF_FFFC;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (load_i) begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, one imem read per instruction, instruction register to decode.
// Optional misaligned-NPC trap (misalign_o, S_HALT) enabled by IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                clk,
   input  logic                rst,
   ifetch_unit_if.master       bus,
   input  logic [31:0]         npc_i,
   output logic [31:0]         pc_o,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic                misalign_o,
`endif
   output logic [31:0]         fetch_count_o
);

   fetch_state_e state_q;
   logic [31:0]  instr_q;
   logic [31:0]  fetchCount_q;
   logic         accept;

   assign accept = (state_q == S_VALID) && bus.instr_ready;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) uPcReg (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .npc_i  (npc_i),
      .pc_o   (pc_o)
   );

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic misalign_q;
   assign misalign_o = misalign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (accept && (npc_i[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end
`endif

   // Reset drops state straight to S_IDLE, so req/valid fall without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         instr_q      <= 32'h0;
         fetchCount_q <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
            end
            S_REQ: begin
               if (bus.imem_ack) begin
                  instr_q <= bus.imem_rdata;
                  state_q <= S_VALID;
               end
            end
            S_VALID: begin
               if (bus.instr_ready) begin
                  fetchCount_q <= fetchCount_q + 32'd1;
`ifdef IFETCH_MISALIGN_TRAP_EN
                  if (npc_i[1:0] != 2'b00) begin
                     state_q <= S_HALT;
                  end else begin
                     state_q <= S_REQ;
                  end
`else
                  state_q <= S_REQ;
`endif
               end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            S_HALT: begin
               state_q <= S_HALT;
            end
`endif
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.imem_req    = (state_q == S_REQ);
   assign bus.imem_addr   = pc_o;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state_q == S_VALID);
   assign fetch_count_o   = fetchCount_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with hand-computed expectations.
// Also covers the misalign trap when IFETCH_MISALIGN_TRAP_EN is defined.
module tb_ifetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] npc;
   logic [31:0] pc;
   logic [31:0] fetchCount;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int total;
   int bad;

   ifetch_unit_if bus ();

   ifetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .npc_i         (npc),
      .pc_o          (pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
      .misalign_o    (misalign),
`endif
      .fetch_count_o (fetchCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison goes through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Inputs are set just after an edge, then one rising edge is taken and we settle 1ns past it.
   task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                input logic ready, input logic [31:0] nextPc);
      bus.imem_ack    = ack;
      bus.imem_rdata  = rdata;
      bus.instr_ready = ready;
      npc             = nextPc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [31:0] expPc;
   logic [31:0] words [3];

   initial begin
      total = 0;
      bad   = 0;
      words[0] = 32'h2408_0005;
      words[1] = 32'h2409_0007;
      words[2] = 32'h0109_5020;

      rst             = 1'b1;
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = words[0];
      bus.instr_ready = 1'b0;
      npc             = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_req",   {31'b0, bus.imem_req},    32'd0);
      checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
      checkOutput("rst_instr", bus.instr,                32'h0);
      checkOutput("rst_count", fetchCount,               32'h0);
      checkOutput("rst_pc",    pc,                       32'h0000_3000);

      // Reset release: first edge IDLE->REQ; ack held high is ignored in IDLE.
      rst = 1'b0;
      applyStimulus(1'b1, words[0], 1'b0, 32'h0);
      checkOutput("first_req",   {31'b0, bus.imem_req}, 32'd1);
      checkOutput("first_addr",  bus.imem_addr,         32'h0000_3000);
      checkOutput("first_instr", bus.instr,             32'h0);
      applyStimulus(1'b1, words[0], 1'b0, 32'h0);
      checkOutput("first_valid",   {31'b0, bus.instr_valid}, 32'd1);
      checkOutput("first_req_off", {31'b0, bus.imem_req},    32'd0);
      checkOutput("first_word",    bus.instr,                32'h2408_0005);

      // Sequential stream, zero-wait memory, decode always ready.
      expPc = 32'h0000_3000;
      for (int i = 0; i < 3; i++) begin
         expPc = expPc + 32'd4;
         applyStimulus(1'b1, words[(i + 1) % 3], 1'b1, expPc);
         checkOutput("seq_req",   {31'b0, bus.imem_req}, 32'd1);
         checkOutput("seq_addr",  bus.imem_addr,         expPc);
         checkOutput("seq_count", fetchCount,            32'(i + 1));
         if (i < 2) begin
            applyStimulus(1'b1, words[(i + 1) % 3], 1'b1, expPc + 32'd4);
            checkOutput("seq_valid", {31'b0, bus.instr_valid}, 32'd1);
            checkOutput("seq_word",  bus.instr,                words[(i + 1) % 3]);
         end
      end
      checkOutput("seq_count3", fetchCount, 32'd3);

      // Memory wait states at 0x300C: request stays up, address and old instr stable.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_3010);
         checkOutput("wait_req",   {31'b0, bus.imem_req}, 32'd1);
         checkOutput("wait_addr",  bus.imem_addr,         32'h0000_300C);
         checkOutput("wait_instr", bus.instr,             words[2]);
      end
      applyStimulus(1'b1, 32'h8C08_0010, 1'b0, 32'h0000_3010);
      checkOutput("wait_word", bus.instr, 32'h8C08_0010);

      // Decode stall: no new request, pc and instr held, late acks ignored.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h1234_5678, 1'b0, 32'h0000_3010);
         checkOutput("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
         checkOutput("stall_req",   {31'b0, bus.imem_req},    32'd0);
         checkOutput("stall_instr", bus.instr,                32'h8C08_0010);
         checkOutput("stall_pc",    pc,                       32'h0000_300C);
      end

      // Branch redirect on accept.
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_3040);
      checkOutput("redir_addr",  bus.imem_addr, 32'h0000_3040);
      checkOutput("redir_req",   {31'b0, bus.imem_req}, 32'd1);
      checkOutput("redir_count", fetchCount,    32'd4);

      // Reset while in S_REQ: request must drop without a clock edge.
      bus.imem_ack = 1'b1;
      rst = 1'b1;
      #2;
      checkOutput("mid_rst_req",   {31'b0, bus.imem_req}, 32'd0);
      checkOutput("mid_rst_pc",    pc,                    32'h0000_3000);
      checkOutput("mid_rst_count", fetchCount,            32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
      checkOutput("post_rst_addr",  bus.imem_addr, 32'h0000_3000);
      checkOutput("post_rst_req",   {31'b0, bus.imem_req}, 32'd1);
      checkOutput("post_rst_instr", bus.instr,     32'h0);
      checkOutput("post_rst_count", fetchCount,    32'd0);
      applyStimulus(1'b1, 32'h1000_FFFF, 1'b0, 32'h0);
      checkOutput("post_rst_word", bus.instr, 32'h1000_FFFF);

      // Misaligned next PC.
      applyStimulus(1'b1, 32'h0, 1'b1, 32'h0000_3042);
      checkOutput("mis_count", fetchCount, 32'd1);
`ifdef IFETCH_MISALIGN_TRAP_EN
      checkOutput("mis_flag",  {31'b0, misalign},        32'd1);
      checkOutput("mis_pc",    pc,                       32'h0000_3042);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h0, 1'b1, 32'h0000_3048);
         checkOutput("halt_req",   {31'b0, bus.imem_req},    32'd0);
         checkOutput("halt_valid", {31'b0, bus.instr_valid}, 32'd0);
      end
`else
      checkOutput("mis_addr", bus.imem_addr,         32'h0000_3040);
      checkOutput("mis_req",  {31'b0, bus.imem_req}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
